demux_param_reg: RTL and testbench

DEMUX_PARAM_REG -- requirements
Module: demux_param_reg

---
 rtl/demux_param_reg.sv | 104 ++++++++++
 tb/tb_demux_param_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_param_reg.sv
// Registered 1-to-N_OUT demultiplexer with valid/ready handshakes, one
// holding register per channel, and drop accounting for out-of-range selects.
module demux_param_reg #(
    parameter int WIDTH = 4,
    parameter int N_OUT = 4,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   sel_err,
    output logic [7:0]             drop_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    chan_state_e      state_q [N_OUT];
    chan_state_e      state_d [N_OUT];
    logic [WIDTH-1:0] data_q  [N_OUT];
    logic [WIDTH-1:0] data_d  [N_OUT];
    logic             sel_err_q, sel_err_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             sel_ok;
    logic             dest_busy;
    logic             in_xfer;
    logic [N_OUT-1:0] load;

    // Select decode is a compare loop so an out-of-range in_sel never indexes past N_OUT.
    always_comb begin
        sel_ok    = 1'b0;
        dest_busy = 1'b0;
        load      = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_ok    = 1'b1;
                dest_busy = (state_q[k] == FULL) & ~out_ready[k];
            end
        end
        in_ready = rst | ~sel_ok | ~dest_busy;
        in_xfer  = in_valid & in_ready;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            load[k] = in_xfer & (in_sel == SEL_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            sel_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            sel_err_q  <= sel_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // A load wins over a drain on the same channel, giving bubble-free pass-through.
    always_comb begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (load[k]) begin
                state_d[k] = FULL;
                data_d[k]  = in_data;
            end else if ((state_q[k] == FULL) && out_ready[k]) begin
                state_d[k] = EMPTY;
            end
        end
        sel_err_d  = in_xfer & ~sel_ok;
        drop_cnt_d = drop_cnt_q;
        if (sel_err_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            out_valid[k]                = (state_q[k] == FULL);
            out_data[k*WIDTH +: WIDTH]  = data_q[k];
        end
        sel_err  = sel_err_q;
        drop_cnt = drop_cnt_q;
    end

endmodule

// File: tb/tb_demux_param_reg.sv
// Directed and randomized checks of demux_param_reg: a 4-channel instance and a
// 3-channel instance that exercises out-of-range selects.
module tb_demux_param_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [3:0]  a_in_data = '0;
    logic [1:0]  a_in_sel = '0;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready = '0;
    logic [15:0] a_out_data;
    logic        a_sel_err;
    logic [7:0]  a_drop_cnt;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [3:0]  b_in_data = '0;
    logic [1:0]  b_in_sel = '0;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready = '0;
    logic [11:0] b_out_data;
    logic        b_sel_err;
    logic [7:0]  b_drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux_param_reg #(.WIDTH(4), .N_OUT(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_sel(a_in_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .sel_err(a_sel_err), .drop_cnt(a_drop_cnt)
    );

    demux_param_reg #(.WIDTH(4), .N_OUT(3)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_sel(b_in_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .sel_err(b_sel_err), .drop_cnt(b_drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          q [4][$];
    int          accepted;
    int          delivered;
    int          sel;
    logic        exp_rdy;
    int          exp_drop;

    initial begin
        // Reset: everything cleared, in_ready forced high even with a word offered
        a_in_valid = 1'b1;
        a_in_sel   = 2'd1;
        a_in_data  = 4'h3;
        tick();
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_sel_err", a_sel_err, 0);
        chk("rst_drop_cnt", a_drop_cnt, 0);
        rst        = 1'b0;
        a_in_valid = 1'b0;
        tick();
        chk("post_rst_out_valid", a_out_valid, 0);

        // Basic route to channel 2, then held with out_ready low
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd2;
        a_in_data   = 4'hA;
        a_out_ready = 4'b0000;
        #1;
        chk("route_in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        chk("route_out_valid", a_out_valid, 4'b0100);
        chk("route_out_data", a_out_data[11:8], 4'hA);
        tick();
        chk("route_hold_valid", a_out_valid, 4'b0100);
        chk("route_hold_data", a_out_data[11:8], 4'hA);

        // Backpressure on channel 2
        a_in_valid = 1'b1;
        a_in_data  = 4'h7;
        #1;
        chk("bp_in_ready_low", a_in_ready, 0);
        tick();
        chk("bp_no_change_data", a_out_data[11:8], 4'hA);
        chk("bp_no_change_valid", a_out_valid, 4'b0100);
        a_out_ready = 4'b0100;
        #1;
        chk("bp_in_ready_high", a_in_ready, 1);
        tick();
        a_in_valid  = 1'b0;
        a_out_ready = 4'b0000;
        chk("bp_pass_data", a_out_data[11:8], 4'h7);
        chk("bp_pass_valid", a_out_valid, 4'b0100);

        // Independence: channel 0 accepts while channel 2 stalls
        a_in_valid = 1'b1;
        a_in_sel   = 2'd0;
        a_in_data  = 4'h5;
        #1;
        chk("indep_in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        chk("indep_out_valid", a_out_valid, 4'b0101);
        chk("indep_ch0_data", a_out_data[3:0], 4'h5);
        chk("indep_ch2_data", a_out_data[11:8], 4'h7);

        // Two channels drain together; data is retained while empty
        a_out_ready = 4'b0101;
        tick();
        a_out_ready = 4'b0000;
        chk("drain_out_valid", a_out_valid, 4'b0000);
        chk("drain_ch0_kept", a_out_data[3:0], 4'h5);

        // Reset mid-operation with channels 0 and 3 full and a transfer offered
        a_in_valid = 1'b1;
        a_in_sel   = 2'd0;
        a_in_data  = 4'h1;
        tick();
        a_in_sel  = 2'd3;
        a_in_data = 4'h3;
        tick();
        chk("mid_pre_valid", a_out_valid, 4'b1001);
        a_in_sel  = 2'd1;
        a_in_data = 4'h9;
        rst       = 1'b1;
        #1;
        chk("mid_rst_in_ready", a_in_ready, 1);
        tick();
        rst        = 1'b0;
        a_in_valid = 1'b0;
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_out_data", a_out_data, 0);
        chk("mid_rst_drop_cnt", a_drop_cnt, 0);
        chk("mid_rst_sel_err", a_sel_err, 0);

        // Randomized sweep against a per-channel FIFO scoreboard
        accepted  = 0;
        delivered = 0;
        for (int i = 0; i < 400; i++) begin
            sel         = i % 4;
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_sel    = 2'(sel);
            a_in_data   = 4'(i);
            a_out_ready = 4'($urandom);
            #1;
            exp_rdy = (q[sel].size() == 0) || a_out_ready[sel];
            chk("sweep_in_ready", a_in_ready, exp_rdy);
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() > 0) begin
                    chk("sweep_valid_full", a_out_valid[k], 1);
                    chk("sweep_data", a_out_data[k*4 +: 4], q[k][0]);
                    if (a_out_ready[k]) begin
                        void'(q[k].pop_front());
                        delivered++;
                    end
                end else begin
                    chk("sweep_valid_empty", a_out_valid[k], 0);
                end
            end
            if (a_in_valid && exp_rdy) begin
                q[sel].push_back(i % 16);
                accepted++;
            end
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            if (q[k].size() > 0) begin
                chk("flush_data", a_out_data[k*4 +: 4], q[k][0]);
                void'(q[k].pop_front());
                delivered++;
            end
        end
        tick();
        a_out_ready = 4'b0000;
        chk("flush_out_valid", a_out_valid, 0);
        chk("sweep_no_loss", delivered, accepted);

        // Out-of-range select on the 3-channel instance
        b_in_valid = 1'b1;
        b_in_sel   = 2'd1;
        b_in_data  = 4'h6;
        tick();
        chk("inv_pre_valid", b_out_valid, 3'b010);
        b_in_sel  = 2'd3;
        b_in_data = 4'hF;
        #1;
        chk("inv_in_ready", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
        chk("inv_sel_err", b_sel_err, 1);
        chk("inv_drop_cnt", b_drop_cnt, 1);
        chk("inv_out_valid", b_out_valid, 3'b010);
        chk("inv_ch1_data", b_out_data[7:4], 4'h6);
        tick();
        chk("inv_sel_err_pulse", b_sel_err, 0);
        chk("inv_drop_hold", b_drop_cnt, 1);

        b_in_valid = 1'b1;
        for (int n = 2; n <= 300; n++) begin
            tick();
            exp_drop = (n > 255) ? 255 : n;
            chk("sat_drop_cnt", b_drop_cnt, exp_drop);
        end
        b_in_valid = 1'b0;
        tick();
        chk("sat_sel_err_low", b_sel_err, 0);
        chk("sat_drop_final", b_drop_cnt, 255);
        chk("sat_out_valid", b_out_valid, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
